// File: rtl/uart_pkg.sv
// Purpose : shared types and constants for the parametrised UART receiver.
// Latency : n/a (package only).
// Backpressure: n/a.
// Contents: rx_state_e FSM encoding, data-length codes, minimum bit period,
//           data_bits_count() helper mapping the 2-bit length code to a count.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } rx_state_e;

  localparam logic [1:0] DATA_BITS_5 = 2'd0;
  localparam logic [1:0] DATA_BITS_6 = 2'd1;
  localparam logic [1:0] DATA_BITS_7 = 2'd2;
  localparam logic [1:0] DATA_BITS_8 = 2'd3;

  // Shortest bit period that still leaves room for a centred 3-sample vote.
  localparam logic [15:0] MIN_CLKS_PER_BIT = 16'd4;

  function automatic logic [3:0] data_bits_count(input logic [1:0] sel);
    logic [3:0] n;
    case (sel)
      DATA_BITS_5: n = 4'd5;
      DATA_BITS_6: n = 4'd6;
      DATA_BITS_7: n = 4'd7;
      DATA_BITS_8: n = 4'd8;
      default:     n = 4'd8;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Purpose : synchronous receive FIFO with registered head data.
// Latency : push visible on rdata/empty/level one cycle later; pop likewise.
// Backpressure: push while full without a pop drops the word and pulses overflow.
// Ports   : clk_i, rst_ni, push/push_data, pop, rdata (head, 0 when empty),
//           full, empty, level (entries held), overflow (1-cycle pulse).
module uart_rx_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  localparam int AW        = $clog2(FIFO_DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       level,
  output logic              overflow
);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr, wr_next, rd_next;
  logic              push_ok, pop_ok, next_empty;
  logic [AW-1:0]     head_idx;
  logic [DATA_W-1:0] head_data;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = wr_ptr - rd_ptr;

  // A pop frees the slot in the same cycle, so push-while-full succeeds with it.
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;

  assign wr_next    = wr_ptr + (AW+1)'(push_ok);
  assign rd_next    = rd_ptr + (AW+1)'(pop_ok);
  assign next_empty = (wr_next == rd_next);
  assign head_idx   = rd_next[AW-1:0];

  // The next head may be the word being written this cycle (FIFO drained to it).
  assign head_data = (push_ok && (head_idx == wr_ptr[AW-1:0])) ? push_data : mem[head_idx];

  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rdata    <= '0;
      overflow <= 1'b0;
    end else begin
      wr_ptr   <= wr_next;
      rd_ptr   <= rd_next;
      rdata    <= next_empty ? '0 : head_data;
      overflow <= push && full && !pop;
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// Purpose : UART receiver, run-time format (5-8 data, opt. parity, 1/2 stop),
//           majority-vote sampling, frame/parity/break detection, receive FIFO.
// Latency : start seen 3 cycles after rx falls; push/error pulse 1 cycle after
//           the last stop sample; rvalid_o 1 cycle after push into empty FIFO.
// Backpressure: the serial line cannot be stalled; a full FIFO drops the frame
//           and pulses overflow_o. Pop with rvalid_o & rready_i.
// Macro   : UART_RX_PARITY_EN builds the PARITY state and parity_err_o; when
//           undefined parity_en_i/parity_odd_i are ignored and parity_err_o is 0.
// Ports   : clk_i, rst_ni, rx_i, clks_per_bit_i, data_bits_i, parity_en_i,
//           parity_odd_i, stop2_i, rdata_o, rvalid_o, rready_i, fifo_level_o,
//           frame_err_o, parity_err_o, break_o, overflow_o.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          rx_i,
  input  logic [15:0]                   clks_per_bit_i,
  input  logic [1:0]                    data_bits_i,
  input  logic                          parity_en_i,
  input  logic                          parity_odd_i,
  input  logic                          stop2_i,
  output logic [DATA_W-1:0]             rdata_o,
  output logic                          rvalid_o,
  input  logic                          rready_i,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          frame_err_o,
  output logic                          parity_err_o,
  output logic                          break_o,
  output logic                          overflow_o
);

  logic              rx_meta, rx_sync;
  logic [2:0]        rx_hist;
  logic              sample;

  rx_state_e         state;
  logic [15:0]       cnt, cnt_inc, cpb_q;
  logic [3:0]        nbits_q, bit_cnt;
  logic              stop2_q, stop_idx, stop1_q;
  logic [DATA_W-1:0] shreg;
  logic              frame_push, frame_err_q, break_q;
  logic              at_half, at_bit;
  logic              stop1_bit, stops_ok, data_zero, par_zero, par_bad, is_break;
  logic              fifo_full, fifo_empty;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_hist <= 3'b111;
    end else begin
      rx_meta <= rx_i;
      rx_sync <= rx_meta;
      rx_hist <= {rx_hist[1:0], rx_sync};
    end
  end

  assign sample = (rx_hist[0] & rx_hist[1]) | (rx_hist[1] & rx_hist[2]) | (rx_hist[0] & rx_hist[2]);

  assign at_half = (cnt == ((cpb_q - 16'd1) >> 1));
  assign at_bit  = (cnt == (cpb_q - 16'd1));
  // Saturate rather than wrap; only reachable if a sample point is never hit.
  assign cnt_inc = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;

  // With two stop bits the first one was captured into stop1_q a bit earlier.
  assign stop1_bit = stop_idx ? stop1_q : sample;
  assign stops_ok  = stop_idx ? (stop1_q & sample) : sample;
  assign data_zero = (shreg == '0);
  assign is_break  = data_zero && par_zero && !stop1_bit;

`ifdef UART_RX_PARITY_EN
  logic par_en_q, par_odd_q, par_bit_q, parity_err_q;
  assign par_zero     = !par_en_q || !par_bit_q;
  assign par_bad      = par_en_q && (par_bit_q != ((^shreg) ^ par_odd_q));
  assign parity_err_o = parity_err_q;
`else
  logic unused_parity_cfg;
  assign unused_parity_cfg = parity_en_i ^ parity_odd_i;
  assign par_zero          = 1'b1;
  assign par_bad           = 1'b0;
  assign parity_err_o      = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      cpb_q       <= MIN_CLKS_PER_BIT;
      nbits_q     <= 4'd8;
      bit_cnt     <= '0;
      stop2_q     <= 1'b0;
      stop_idx    <= 1'b0;
      stop1_q     <= 1'b1;
      shreg       <= '0;
      frame_push  <= 1'b0;
      frame_err_q <= 1'b0;
      break_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_en_q     <= 1'b0;
      par_odd_q    <= 1'b0;
      par_bit_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      frame_push  <= 1'b0;
      frame_err_q <= 1'b0;
      break_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (!rx_sync) begin
            state    <= ST_START;
            cpb_q    <= (clks_per_bit_i < MIN_CLKS_PER_BIT) ? MIN_CLKS_PER_BIT : clks_per_bit_i;
            nbits_q  <= data_bits_count(data_bits_i);
            stop2_q  <= stop2_i;
            bit_cnt  <= '0;
            stop_idx <= 1'b0;
            shreg    <= '0;
`ifdef UART_RX_PARITY_EN
            par_en_q  <= parity_en_i;
            par_odd_q <= parity_odd_i;
`endif
          end
        end
        ST_START: begin
          if (at_half) begin
            cnt   <= '0;
            // A high vote at mid start bit was only a glitch.
            state <= sample ? ST_IDLE : ST_DATA;
          end else begin
            cnt <= cnt_inc;
          end
        end
        ST_DATA: begin
          if (at_bit) begin
            cnt     <= '0;
            shreg   <= shreg | (DATA_W'(sample) << bit_cnt);
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == nbits_q - 4'd1) begin
`ifdef UART_RX_PARITY_EN
              state <= par_en_q ? ST_PARITY : ST_STOP;
`else
              state <= ST_STOP;
`endif
            end
          end else begin
            cnt <= cnt_inc;
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (at_bit) begin
            cnt       <= '0;
            par_bit_q <= sample;
            state     <= ST_STOP;
          end else begin
            cnt <= cnt_inc;
          end
        end
`endif
        ST_STOP: begin
          if (at_bit) begin
            cnt <= '0;
            if (stop2_q && !stop_idx) begin
              stop1_q  <= sample;
              stop_idx <= 1'b1;
            end else if (is_break) begin
              break_q <= 1'b1;
              state   <= ST_WAIT_HIGH;
            end else begin
              state <= ST_IDLE;
              if (!stops_ok) begin
                frame_err_q <= 1'b1;
              end else if (par_bad) begin
`ifdef UART_RX_PARITY_EN
                parity_err_q <= 1'b1;
`endif
              end else begin
                frame_push <= 1'b1;
              end
            end
          end else begin
            cnt <= cnt_inc;
          end
        end
        ST_WAIT_HIGH: begin
          cnt <= '0;
          if (rx_sync) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign frame_err_o = frame_err_q;
  assign break_o     = break_q;

  // shreg is held until the next start, so it is still the frame word when
  // frame_push is seen one cycle after the last stop sample.
  uart_rx_fifo #(
    .DATA_W    (DATA_W),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .push     (frame_push),
    .push_data(shreg),
    .pop      (rvalid_o && rready_i),
    .rdata    (rdata_o),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (fifo_level_o),
    .overflow (overflow_o)
  );

  assign rvalid_o = !fifo_empty;

  logic unused_fifo_full;
  assign unused_fifo_full = fifo_full;

endmodule

// File: tb/tb_uart_rx_param.sv
module tb_uart_rx_param;

  localparam int CPB = 16;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        rx_i;
  logic [15:0] clks_per_bit_i;
  logic [1:0]  data_bits_i;
  logic        parity_en_i, parity_odd_i, stop2_i;
  logic [7:0]  rdata_o;
  logic        rvalid_o;
  logic        rready_i;
  logic [2:0]  fifo_level_o;
  logic        frame_err_o, parity_err_o, break_o, overflow_o;

  uart_rx_param #(.DATA_W(8), .FIFO_DEPTH(4)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .rx_i          (rx_i),
    .clks_per_bit_i(clks_per_bit_i),
    .data_bits_i   (data_bits_i),
    .parity_en_i   (parity_en_i),
    .parity_odd_i  (parity_odd_i),
    .stop2_i       (stop2_i),
    .rdata_o       (rdata_o),
    .rvalid_o      (rvalid_o),
    .rready_i      (rready_i),
    .fifo_level_o  (fifo_level_o),
    .frame_err_o   (frame_err_o),
    .parity_err_o  (parity_err_o),
    .break_o       (break_o),
    .overflow_o    (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int passes = 0;
  int fe_cnt = 0, pe_cnt = 0, brk_cnt = 0, ov_cnt = 0;
  logic [7:0] exp_q[$];

  always @(posedge clk_i) begin
    if (frame_err_o === 1'b1)  fe_cnt  <= fe_cnt + 1;
    if (parity_err_o === 1'b1) pe_cnt  <= pe_cnt + 1;
    if (break_o === 1'b1)      brk_cnt <= brk_cnt + 1;
    if (overflow_o === 1'b1)   ov_cnt  <= ov_cnt + 1;
  end

  task automatic send_bit(input logic b);
    rx_i = b;
    repeat (CPB) @(negedge clk_i);
  endtask

  task automatic idle(input int n);
    rx_i = 1'b1;
    repeat (n) @(negedge clk_i);
  endtask

  // Serialises one frame; parity bit derived here (flip forces a wrong one).
  // cfg_change scrambles data_bits_i after the start bit to prove latching.
  task automatic send_frame(input logic [7:0] d, input int nbits, input bit par,
                            input bit odd, input bit flip, input bit two_stop,
                            input logic s1, input logic s2, input bit cfg_change);
    logic       p;
    logic [1:0] saved;
    p = odd ^ flip;
    saved = data_bits_i;
    send_bit(1'b0);
    if (cfg_change) data_bits_i = ~data_bits_i;
    for (int i = 0; i < nbits; i++) begin
      send_bit(d[i]);
      p = p ^ d[i];
    end
    if (par) send_bit(p);
    send_bit(s1);
    if (two_stop) send_bit(s2);
    data_bits_i = saved;
    rx_i = 1'b1;
  endtask

  task automatic pop_word(output logic [7:0] d, output bit ok);
    ok = 1'b0;
    d  = '0;
    for (int i = 0; i < 400; i++) begin
      if (rvalid_o === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk_i);
    end
    if (ok) begin
      d = rdata_o;
      rready_i = 1'b1;
      @(negedge clk_i);
      rready_i = 1'b0;
    end
  endtask

  task automatic set_fmt(input logic [1:0] db, input bit pe, input bit po, input bit s2);
    data_bits_i  = db;
    parity_en_i  = pe;
    parity_odd_i = po;
    stop2_i      = s2;
  endtask

  task automatic test_reset;
    rst_ni = 1'b0;
    rx_i = 1'b1;
    rready_i = 1'b0;
    clks_per_bit_i = 16'(CPB);
    set_fmt(2'd3, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk_i);
    checks++;
    if (rvalid_o !== 1'b0) $display("FAIL reset_rvalid: got %b want 0", rvalid_o); else passes++;
    checks++;
    if (rdata_o !== 8'h00) $display("FAIL reset_rdata: got %h want 00", rdata_o); else passes++;
    checks++;
    if (fifo_level_o !== 3'd0) $display("FAIL reset_level: got %0d want 0", fifo_level_o); else passes++;
    checks++;
    if ({frame_err_o, parity_err_o, break_o, overflow_o} !== 4'b0)
      $display("FAIL reset_pulses: got %b want 0000", {frame_err_o, parity_err_o, break_o, overflow_o});
    else passes++;
    rst_ni = 1'b1;
    idle(4);
  endtask

  task automatic test_8n1;
    int fe0, pe0, b0;
    logic [7:0] got, exp;
    bit ok;
    fe0 = fe_cnt; pe0 = pe_cnt; b0 = brk_cnt;
    set_fmt(2'd3, 1'b0, 1'b0, 1'b0);
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    exp_q.push_back(8'hA5);
    idle(8);
    checks++;
    if (rvalid_o !== 1'b1 || rdata_o !== exp_q[0])
      $display("FAIL 8n1_head: got v=%b d=%h want v=1 d=%h", rvalid_o, rdata_o, exp_q[0]);
    else passes++;
    checks++;
    if (fifo_level_o !== 3'd1) $display("FAIL 8n1_level: got %0d want 1", fifo_level_o); else passes++;
    checks++;
    if (fe_cnt != fe0 || pe_cnt != pe0 || brk_cnt != b0)
      $display("FAIL 8n1_no_err: got fe=%0d pe=%0d brk=%0d new pulses want 0", fe_cnt-fe0, pe_cnt-pe0, brk_cnt-b0);
    else passes++;
    pop_word(got, ok);
    exp = exp_q.pop_front();
    checks++;
    if (!ok || got !== exp) $display("FAIL 8n1_pop: got ok=%b d=%h want %h", ok, got, exp); else passes++;
    // 5-bit frame, format scrambled mid-frame: upper bits must read 0.
    set_fmt(2'd0, 1'b0, 1'b0, 1'b0);
    send_frame(8'hF5, 5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    exp_q.push_back(8'h15);
    idle(8);
    pop_word(got, ok);
    exp = exp_q.pop_front();
    checks++;
    if (!ok || got !== exp) $display("FAIL 5n1_latched: got ok=%b d=%h want %h", ok, got, exp); else passes++;
    checks++;
    if (fifo_level_o !== 3'd0) $display("FAIL 5n1_level_after_pop: got %0d want 0", fifo_level_o); else passes++;
  endtask

  task automatic test_back_to_back;
    logic [7:0] got, exp;
    bit ok;
    set_fmt(2'd3, 1'b0, 1'b0, 1'b0);
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    exp_q.push_back(8'h3C);
    send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    exp_q.push_back(8'hC3);
    idle(8);
    for (int k = 0; k < 2; k++) begin
      pop_word(got, ok);
      exp = exp_q.pop_front();
      checks++;
      if (!ok || got !== exp) $display("FAIL b2b_pop%0d: got ok=%b d=%h want %h", k, ok, got, exp); else passes++;
    end
  endtask

  task automatic test_parity;
    int pe0;
    logic [7:0] got, exp;
    bit ok;
    pe0 = pe_cnt;
`ifdef UART_RX_PARITY_EN
    set_fmt(2'd2, 1'b1, 1'b0, 1'b0);
    send_frame(8'h3C, 7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(8);
    checks++;
    if (pe_cnt - pe0 != 1) $display("FAIL par_err_pulse: got %0d pulses want 1", pe_cnt - pe0); else passes++;
    checks++;
    if (fifo_level_o !== 3'd0) $display("FAIL par_err_level: got %0d want 0", fifo_level_o); else passes++;
    set_fmt(2'd2, 1'b1, 1'b1, 1'b0);
    send_frame(8'h55, 7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    exp_q.push_back(8'h55);
    idle(8);
    pop_word(got, ok);
    exp = exp_q.pop_front();
    checks++;
    if (!ok || got !== exp) $display("FAIL par_odd_ok: got ok=%b d=%h want %h", ok, got, exp); else passes++;
`else
    // Parity support not built: parity_en_i must be ignored, frame is 7N1.
    set_fmt(2'd2, 1'b1, 1'b0, 1'b0);
    send_frame(8'h3C, 7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    exp_q.push_back(8'h3C);
    idle(8);
    pop_word(got, ok);
    exp = exp_q.pop_front();
    checks++;
    if (!ok || got !== exp) $display("FAIL par_ignored: got ok=%b d=%h want %h", ok, got, exp); else passes++;
    checks++;
    if (pe_cnt != pe0) $display("FAIL par_tied: got %0d pulses want 0", pe_cnt - pe0); else passes++;
`endif
  endtask

  task automatic test_break;
    int b0, fe0;
    logic [7:0] got, exp;
    bit ok;
    b0 = brk_cnt; fe0 = fe_cnt;
    set_fmt(2'd3, 1'b0, 1'b0, 1'b0);
    rx_i = 1'b0;
    repeat (12 * CPB) @(negedge clk_i);
    checks++;
    if (rvalid_o !== 1'b0 || fifo_level_o !== 3'd0)
      $display("FAIL break_no_push: got v=%b lvl=%0d want 0/0", rvalid_o, fifo_level_o);
    else passes++;
    idle(2 * CPB);
    checks++;
    if (brk_cnt - b0 != 1 || fe_cnt != fe0)
      $display("FAIL break_pulse: got brk=%0d fe=%0d want 1/0", brk_cnt - b0, fe_cnt - fe0);
    else passes++;
    send_frame(8'h11, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    exp_q.push_back(8'h11);
    idle(8);
    pop_word(got, ok);
    exp = exp_q.pop_front();
    checks++;
    if (!ok || got !== exp) $display("FAIL break_recover: got ok=%b d=%h want %h", ok, got, exp); else passes++;
  endtask

  task automatic test_overflow;
    int ov0;
    logic [7:0] got, exp;
    bit ok;
    ov0 = ov_cnt;
    set_fmt(2'd3, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      send_frame(8'(k), 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      if (k <= 4) exp_q.push_back(8'(k));
    end
    idle(8);
    checks++;
    if (ov_cnt - ov0 != 1) $display("FAIL ovf_pulse: got %0d pulses want 1", ov_cnt - ov0); else passes++;
    checks++;
    if (fifo_level_o !== 3'd4) $display("FAIL ovf_level: got %0d want 4", fifo_level_o); else passes++;
    for (int k = 0; k < 4; k++) begin
      pop_word(got, ok);
      exp = exp_q.pop_front();
      checks++;
      if (!ok || got !== exp) $display("FAIL ovf_pop%0d: got ok=%b d=%h want %h", k, ok, got, exp); else passes++;
    end
    checks++;
    if (rvalid_o !== 1'b0) $display("FAIL ovf_drained: got rvalid=%b want 0", rvalid_o); else passes++;
  endtask

  task automatic test_glitch;
    int fe0, b0, pe0;
    logic [7:0] got, exp;
    bit ok;
    fe0 = fe_cnt; b0 = brk_cnt; pe0 = pe_cnt;
    rx_i = 1'b0;
    repeat (3) @(negedge clk_i);
    idle(2 * CPB);
    checks++;
    if (fifo_level_o !== 3'd0 || fe_cnt != fe0 || brk_cnt != b0 || pe_cnt != pe0)
      $display("FAIL glitch_ignored: got lvl=%0d fe=%0d brk=%0d pe=%0d want all 0",
               fifo_level_o, fe_cnt - fe0, brk_cnt - b0, pe_cnt - pe0);
    else passes++;
    send_frame(8'h96, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    exp_q.push_back(8'h96);
    idle(8);
    pop_word(got, ok);
    exp = exp_q.pop_front();
    checks++;
    if (!ok || got !== exp) $display("FAIL glitch_then_frame: got ok=%b d=%h want %h", ok, got, exp); else passes++;
  endtask

  task automatic test_stop2;
    int fe0;
    logic [7:0] got, exp;
    bit ok;
    set_fmt(2'd3, 1'b0, 1'b0, 1'b1);
    send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    exp_q.push_back(8'hC3);
    idle(8);
    pop_word(got, ok);
    exp = exp_q.pop_front();
    checks++;
    if (!ok || got !== exp) $display("FAIL 8n2_ok: got ok=%b d=%h want %h", ok, got, exp); else passes++;
    fe0 = fe_cnt;
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(8);
    checks++;
    if (fe_cnt - fe0 != 1 || fifo_level_o !== 3'd0)
      $display("FAIL 8n2_frame_err: got fe=%0d lvl=%0d want 1/0", fe_cnt - fe0, fifo_level_o);
    else passes++;
    set_fmt(2'd3, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_frame;
    int fe0, pe0, b0, ov0;
    logic [7:0] got, exp;
    bit ok;
    fe0 = fe_cnt; pe0 = pe_cnt; b0 = brk_cnt; ov0 = ov_cnt;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    rx_i = 1'b1;
    rst_ni = 1'b0;
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    idle(2 * CPB);
    checks++;
    if (rvalid_o !== 1'b0 || fifo_level_o !== 3'd0 ||
        fe_cnt != fe0 || pe_cnt != pe0 || brk_cnt != b0 || ov_cnt != ov0)
      $display("FAIL rst_abort: got v=%b lvl=%0d pulses=%0d want 0/0/0", rvalid_o, fifo_level_o,
               (fe_cnt - fe0) + (pe_cnt - pe0) + (brk_cnt - b0) + (ov_cnt - ov0));
    else passes++;
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    exp_q.push_back(8'h5A);
    idle(8);
    pop_word(got, ok);
    exp = exp_q.pop_front();
    checks++;
    if (!ok || got !== exp) $display("FAIL rst_then_frame: got ok=%b d=%h want %h", ok, got, exp); else passes++;
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_back_to_back();
    test_parity();
    test_break();
    test_overflow();
    test_glitch();
    test_stop2();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised UART receiver: successor to the fixed 8N1 receiver in the UART peripheral. Adds run-time frame format (5–8 data bits, optional even/odd parity, 1 or 2 stop bits), majority-vote sampling, frame/parity/break detection, and a small receive FIFO with a valid/ready pop interface. Sits between the synchronised `rx` pad and the UART register/TileLink front-end.

## Interface

**Parameters**
- `DATA_W`, default 8: maximum data bits; `rdata_o` width.
- `FIFO_DEPTH`, default 4: receive FIFO entries; power of 2, at least 2.

**Ports**
- `clk_i` in, 1: clock.
- `rst_ni` in, 1: reset; asynchronous, active-low.
- `rx_i` in, 1: serial line, asynchronous to `clk_i`.
- `clks_per_bit_i` in, 16: `clk_i` cycles per bit; minimum 4.
- `data_bits_i` in, 2: data length, 0=5, 1=6, 2=7, 3=8 bits.
- `parity_en_i` in, 1: parity bit present.
- `parity_odd_i` in, 1: 1=odd, 0=even.
- `stop2_i` in, 1: two stop bits.
- `rdata_o` out, DATA_W: FIFO head; LSB-first data, unused upper bits 0.
- `rvalid_o` out, 1: FIFO non-empty.
- `rready_i` in, 1: pop when `rvalid_o & rready_i`.
- `fifo_level_o` out, $clog2(FIFO_DEPTH)+1: entries held.
- `frame_err_o`, `parity_err_o`, `break_o`, `overflow_o` out, 1 each: single-cycle event pulses.

## Operation
- `rx_i` passes through a 2-flop synchroniser (reset value 1), then a 3-bit history register (reset value 111). The sampled bit is the majority of the 3 history bits.
- Format inputs and `clks_per_bit_i` are latched when a start bit is detected. Mid-frame changes have no effect on the current frame.
- FSM states:
  - IDLE: synchronised line 0 → START, counter cleared.
  - START: at count == (clks_per_bit-1)>>1, a majority sample of 0 → DATA with counter cleared; a sample of 1 → IDLE (glitch rejection).
  - DATA: sample every clks_per_bit cycles, LSB first, shifting into the data register. After the latched number of bits → PARITY if enabled, else STOP.
  - PARITY: sample one bit; compare against the XOR of the data bits, inverted when odd parity is selected.
  - STOP: sample the stop bit. If `stop2` is latched, sample a second stop bit one bit period later.
  - On the last stop sample, the frame is evaluated and the FSM returns to IDLE immediately. There is no half-bit wait, so back-to-back frames are accepted.
  - WAIT_HIGH: entered after a break; returns to IDLE once the synchronised line is 1.
- Frame evaluation, highest priority first:
  - Data bits all 0, parity bit (if present) 0, and first stop bit 0 → `break_o` pulse, no push, → WAIT_HIGH.
  - Any stop bit 0 → `frame_err_o` pulse, no push.
  - Parity mismatch → `parity_err_o` pulse, no push.
  - Otherwise push into the FIFO.
- FIFO:
  - Push while full and no pop in the same cycle → word dropped, contents unchanged, `overflow_o` pulse.
  - Push and pop in the same cycle while full → both happen, no overflow.
  - Pop while empty is ignored.
- Counter is 16 bits and never wraps; it is cleared at every sample point.

## Timing
- Reset values: `rvalid_o`=0, `rdata_o`=0, `fifo_level_o`=0, all pulses 0, FSM in IDLE, FIFO pointers 0.
- Reset asserted mid-frame aborts the frame immediately. The FIFO is emptied and no pulse is emitted.
- Start detection occurs 3 cycles after the falling edge on `rx_i` (2 synchroniser flops + IDLE register).
- Push, error pulses and `break_o` assert in the cycle after the final stop-bit sample.
- `rvalid_o` rises in the cycle after a push into an empty FIFO.
- `rdata_o` is registered FIFO-head data, stable while `rvalid_o` is high and no pop occurs.
- `fifo_level_o` updates in the cycle after a push or pop.

## Configuration
- `UART_RX_PARITY_EN` defined: PARITY state, parity check and `parity_err_o` are present.
- Not defined: `parity_en_i` and `parity_odd_i` are ignored, the PARITY state is not built, and `parity_err_o` is tied to 0. Frames are always data + stop.

## Structure
- Shared package `uart_pkg`: FSM state enum, data-length encoding constants, minimum clks_per_bit constant (4).
- Sub-module `uart_rx_fifo`: synchronous FIFO parameterised by `FIFO_DEPTH` and `DATA_W`, exposing push, pop, full, empty, level and an overflow pulse.

## Test plan
- 8N1, clks_per_bit=16, send 0xA5 → `rdata_o`=0xA5 with `rvalid_o` high. No error pulses; `fifo_level_o`=1.
- 7E1 (data_bits=2, parity_en=1), send 0x3C with wrong parity → one `parity_err_o` pulse, `fifo_level_o` stays 0.
- Line held low for 12 bit times → one `break_o` pulse, no push. The next valid 0x11 frame is received only after the line returns high.
- `rready_i`=0, send 5 frames 0x01..0x05 with FIFO_DEPTH=4 → `overflow_o` pulses on the 5th frame. Popping then returns 0x01..0x04 in order.
- 3-cycle low glitch on an idle line at clks_per_bit=16 → no frame and no pulses; FSM back in IDLE.
- 8N2 frame whose second stop bit is 0 → `frame_err_o` pulse, no push.
- Assert `rst_ni` mid-frame, then send 0x5A → the aborted frame leaves no trace, and 0x5A is received cleanly.
